display_sequencer: RTL and testbench

- Parametrised successor of the round display streamer in the colour-memory game datapath.
- Plays back the first N+1 colours of a packed sequence, with a programmable on-time per colour and an off-gap between colours.
- Stalls on a downstream ready signal and supports abort.
- Sits between the sequence generator/round counter and the pad/LED wrapper, which tri-states pads when colour_oe=0.

---
 rtl/display_pkg.sv | 22 ++
 rtl/dwell_counter.sv | 29 ++
 rtl/display_sequencer.sv | 167 ++++++++++++++++
 tb/tb_display_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the colour-memory display sequencer.
package display_pkg;

    localparam int COL_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_GREEN  = 2'd1;
    localparam logic [1:0] COL_BLUE   = 2'd2;
    localparam logic [1:0] COL_YELLOW = 2'd3;

    // Last index to play: a round counter past the sequence end shows the whole sequence.
    function automatic int unsigned clamp_len(input int unsigned rc, input int unsigned max_len);
        return (rc >= max_len) ? max_len - 1 : rc;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter used for both the colour on-time and the inter-colour gap.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic [CNT_W-1:0] value,
    output logic             is_last
);

    logic [CNT_W-1:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (dec_en && (value_q != '0)) begin
            value_q <= value_q - CNT_W'(1);
        end
    end

    assign value   = value_q;
    assign is_last = (value_q == CNT_W'(1));

endmodule

// File: rtl/display_sequencer.sv
// Plays back the first N+1 colours of a snapshotted sequence with a
// ready-gated on-time per colour and an optional blank gap between colours.
module display_sequencer
    import display_pkg::*;
#(
    parameter int COL_W   = COL_W_DEF,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_display,
    input  logic                     start_display,
    input  logic                     abort_display,
    input  logic [COL_W*MAX_LEN-1:0] seq_in_display,
    input  logic [LEN_W-1:0]         round_ctr,
    input  logic [CNT_W-1:0]         on_cycles,
    input  logic [CNT_W-1:0]         off_cycles,
    input  logic                     colour_ready,
    output logic [COL_W-1:0]         colour_bus,
    output logic                     colour_oe,
    output logic                     busy,
    output logic                     complete_display,
    output logic [1:0]               state_dbg
);

    state_e                   state_q;
    logic [COL_W*MAX_LEN-1:0] seq_q;
    logic [LEN_W-1:0]         len_q, pos_q, next_pos;
    logic [CNT_W-1:0]         on_q, off_q, on_eff, dwell_load_val;
    logic [COL_W-1:0]         colour_q, next_colour;
    logic                     oe_q, busy_q, complete_q;

    logic dwell_load, dwell_dec, dwell_last;
    logic gap_load, gap_dec, gap_last;
    logic show_end;
    logic [CNT_W-1:0] unused_dwell_val, unused_gap_val;

    assign on_eff         = (on_cycles == '0) ? CNT_W'(1) : on_cycles;
    assign next_pos       = pos_q + LEN_W'(1);
    assign next_colour    = COL_W'(seq_q >> (COL_W * int'(next_pos)));
    assign dwell_load_val = (state_q == IDLE) ? on_eff : on_q;

    // Counter control; abort suppresses every reload so the counters simply go stale.
    always_comb begin
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        show_end   = 1'b0;
        case (state_q)
            IDLE: dwell_load = start_display && !abort_display;
            SHOW: begin
                dwell_dec = colour_ready;
                show_end  = !abort_display && colour_ready && dwell_last;
                if (show_end && (pos_q != len_q)) begin
                    if (off_q == '0) dwell_load = 1'b1;
                    else             gap_load   = 1'b1;
                end
            end
            GAP: begin
                gap_dec    = 1'b1;
                dwell_load = !abort_display && gap_last;
            end
            default: ;
        endcase
    end

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst_display),
        .load     (dwell_load),
        .load_val (dwell_load_val),
        .dec_en   (dwell_dec),
        .value    (unused_dwell_val),
        .is_last  (dwell_last)
    );

    dwell_counter #(.CNT_W(CNT_W)) u_gap (
        .clk      (clk),
        .rst      (rst_display),
        .load     (gap_load),
        .load_val (off_q),
        .dec_en   (gap_dec),
        .value    (unused_gap_val),
        .is_last  (gap_last)
    );

    always_ff @(posedge clk or posedge rst_display) begin
        if (rst_display) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            len_q      <= '0;
            pos_q      <= '0;
            on_q       <= '0;
            off_q      <= '0;
            colour_q   <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_display && !abort_display) begin
                        seq_q    <= seq_in_display;
                        len_q    <= LEN_W'(clamp_len(32'(round_ctr), MAX_LEN));
                        on_q     <= on_eff;
                        off_q    <= off_cycles;
                        pos_q    <= '0;
                        colour_q <= seq_in_display[COL_W-1:0];
                        oe_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= SHOW;
                    end
                end
                SHOW: begin
                    if (abort_display) begin
                        colour_q <= '0;
                        oe_q     <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (show_end) begin
                        if (pos_q == len_q) begin
                            colour_q   <= '0;
                            oe_q       <= 1'b0;
                            busy_q     <= 1'b0;
                            complete_q <= 1'b1;
                            state_q    <= IDLE;
                        end else if (off_q == '0) begin
                            pos_q    <= next_pos;
                            colour_q <= next_colour;
                        end else begin
                            colour_q <= '0;
                            oe_q     <= 1'b0;
                            state_q  <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (abort_display) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (gap_last) begin
                        pos_q    <= next_pos;
                        colour_q <= next_colour;
                        oe_q     <= 1'b1;
                        state_q  <= SHOW;
                    end
                end
                default: begin
                    colour_q <= '0;
                    oe_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign colour_bus       = colour_q;
    assign colour_oe        = oe_q;
    assign busy             = busy_q;
    assign complete_display = complete_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: per-cycle vector table plus reset and clamp sequences.
module tb_display_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start12, abort, ready;
    logic [31:0] seq;
    logic [23:0] seq12;
    logic [3:0]  round;
    logic [7:0]  on_c, off_c;

    logic [1:0] bus, bus12, st, st12;
    logic       oe, busy, cmp, oe12, busy12, cmp12;

    always #5 clk = ~clk;

    display_sequencer #(.COL_W(2), .MAX_LEN(16), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk              (clk),
        .rst_display      (rst),
        .start_display    (start),
        .abort_display    (abort),
        .seq_in_display   (seq),
        .round_ctr        (round),
        .on_cycles        (on_c),
        .off_cycles       (off_c),
        .colour_ready     (ready),
        .colour_bus       (bus),
        .colour_oe        (oe),
        .busy             (busy),
        .complete_display (cmp),
        .state_dbg        (st)
    );

    display_sequencer #(.COL_W(2), .MAX_LEN(12), .LEN_W(4), .CNT_W(8)) u_dut12 (
        .clk              (clk),
        .rst_display      (rst),
        .start_display    (start12),
        .abort_display    (abort),
        .seq_in_display   (seq12),
        .round_ctr        (round),
        .on_cycles        (on_c),
        .off_cycles       (off_c),
        .colour_ready     (ready),
        .colour_bus       (bus12),
        .colour_oe        (oe12),
        .busy             (busy12),
        .complete_display (cmp12),
        .state_dbg        (st12)
    );

    // exp packs {oe, bus[1:0], busy, complete}
    typedef struct {
        logic       s, a, r;
        logic [3:0] rc;
        logic [7:0] on, off;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b ({oe,bus,busy,complete})", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic a, input logic r, input logic [3:0] rc,
                       input logic [7:0] on, input logic [7:0] off, input logic [4:0] exp);
        vec_t v;
        v.s = s; v.a = a; v.r = r; v.rc = rc; v.on = on; v.off = off; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e;
        rst = 1'b1; start = 1'b0; start12 = 1'b0; abort = 1'b0; ready = 1'b1;
        seq = 32'hE4; seq12 = 24'hE4E4E4; round = 4'd0; on_c = 8'd1; off_c = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", {oe, bus, busy, cmp}, 5'b00000);
        check("reset_state", {3'b000, st}, {3'b000, 2'd0});

        // 4 colours back-to-back, start held high, restart then abort
        add(1, 0, 1, 3, 1, 0, 5'b10010);
        add(1, 0, 1, 3, 1, 0, 5'b10110);
        add(1, 0, 1, 3, 1, 0, 5'b11010);
        add(1, 0, 1, 3, 1, 0, 5'b11110);
        add(1, 0, 1, 3, 1, 0, 5'b00001);
        add(1, 0, 1, 3, 1, 0, 5'b10010);
        add(0, 1, 1, 3, 1, 0, 5'b00000);
        add(0, 0, 1, 3, 1, 0, 5'b00000);
        // on=3 off=2 two colours; inputs changed after snapshot
        add(1, 0, 1, 1, 3, 2, 5'b10010);
        add(0, 0, 1, 0, 7, 0, 5'b10010);
        add(0, 0, 1, 0, 7, 0, 5'b10010);
        add(0, 0, 1, 0, 7, 0, 5'b00010);
        add(0, 0, 1, 0, 7, 0, 5'b00010);
        add(0, 0, 1, 0, 7, 0, 5'b10110);
        add(0, 0, 1, 0, 7, 0, 5'b10110);
        add(0, 0, 1, 0, 7, 0, 5'b10110);
        add(0, 0, 1, 0, 7, 0, 5'b00001);
        add(0, 0, 1, 0, 7, 0, 5'b00000);
        // on=2, ready low 4 cycles inside colour 0
        add(1, 0, 1, 1, 2, 0, 5'b10010);
        add(0, 0, 1, 1, 2, 0, 5'b10010);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 2, 0, 5'b10010);
        add(0, 0, 1, 1, 2, 0, 5'b10110);
        add(0, 0, 1, 1, 2, 0, 5'b10110);
        add(0, 0, 1, 1, 2, 0, 5'b00001);
        // abort priority in IDLE, abort in GAP, abort on final dwell end
        add(1, 1, 1, 3, 1, 2, 5'b00000);
        add(0, 1, 1, 3, 1, 2, 5'b00000);
        add(1, 0, 1, 3, 1, 2, 5'b10010);
        add(0, 0, 1, 3, 1, 2, 5'b00010);
        add(0, 0, 1, 3, 1, 2, 5'b00010);
        add(0, 0, 1, 3, 1, 2, 5'b10110);
        add(0, 0, 1, 3, 1, 2, 5'b00010);
        add(0, 1, 1, 3, 1, 2, 5'b00000);
        add(0, 0, 1, 3, 1, 2, 5'b00000);
        add(1, 0, 1, 0, 1, 2, 5'b10010);
        add(0, 1, 1, 0, 1, 2, 5'b00000);
        add(0, 0, 1, 0, 1, 2, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].s; abort = vecs[i].a; ready = vecs[i].r;
            round = vecs[i].rc; on_c = vecs[i].on; off_c = vecs[i].off;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), {oe, bus, busy, cmp}, vecs[i].exp);
        end
        start = 1'b0; abort = 1'b0; ready = 1'b1;

        // Asynchronous reset between edges during SHOW
        round = 4'd3; on_c = 8'd5; off_c = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("rst_pre_show", {oe, bus, busy, cmp}, 5'b10010);
        #3 rst = 1'b1;
        #1 check("rst_async", {oe, bus, busy, cmp}, 5'b00000);
        check("rst_async_state", {3'b000, st}, 5'b00000);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("rst_idle%0d", i), {oe, bus, busy, cmp}, 5'b00000);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("rst_restart", {oe, bus, busy, cmp}, 5'b10010);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("rst_abort", {oe, bus, busy, cmp}, 5'b00000);

        // round_ctr=F clamps to 12 colours on the MAX_LEN=12 instance
        round = 4'hF; on_c = 8'd1; off_c = 8'd0;
        for (int i = 0; i < 12; i++) exp_q.push_back(2'(i % 4));
        start12 = 1'b1;
        @(posedge clk);
        #1 start12 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            check($sformatf("len12_c%0d", i), {oe12, bus12, busy12, cmp12}, {1'b1, e, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        check("len12_done", {oe12, bus12, busy12, cmp12}, 5'b00001);
        @(posedge clk);
        #1 check("len12_idle", {oe12, bus12, busy12, cmp12}, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
